// File: rtl/mipi_pkg.sv
// Shared types and helpers for the MIPI RAW12 line packer.
// Pixel pairs are packed as byte0 = P0 MSBs, byte1 = P1 MSBs, byte2 = {P1 LSBs, P0 LSBs}.
package mipi_pkg;

    localparam int DEFAULT_LINE_PIXELS = 3072;
    localparam int DEFAULT_FIFO_DEPTH  = 16;
    localparam int FIFO_ENTRY_W        = 26;   // {tlast, tuser, data[23:0]}

    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_PIX0     = 2'd1,
        S_PIX1     = 2'd2
    } packer_state_t;

    function automatic logic [23:0] pack_raw12_pair(input logic [11:0] p0, input logic [11:0] p1);
        return {p1[3:0], p0[3:0], p1[11:4], p0[11:4]};
    endfunction

endpackage

// File: rtl/mipi_pix_fifo.sv
// Show-ahead output FIFO for packed words; head entry is valid whenever the FIFO is not empty.
// Synchronous clear empties it in one cycle; stored data is left as-is.
module mipi_pix_fifo
    import mipi_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic [FIFO_ENTRY_W-1:0] push_entry,
    input  logic                    pop,
    output logic [FIFO_ENTRY_W-1:0] head,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [FIFO_ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    wr_en;
    logic                    rd_en;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/mipi_raw12_line_packer.sv
// Packs RAW12 pixel pairs into 24-bit AXI-Stream words with line/frame markers.
// state      | meaning
// S_WAIT_SOF | dropping pixels until a start-of-frame pixel arrives
// S_PIX0     | no pixel held, next pixel becomes P0
// S_PIX1     | P0 held, next pixel completes the pair and writes a word
module mipi_raw12_line_packer
    import mipi_pkg::*;
#(
    parameter int LINE_PIXELS = DEFAULT_LINE_PIXELS,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic        dphy_clk_200M,
    input  logic        rst_n_200mhz,
    input  logic        read_frame_reset,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic [23:0] axis_tdata_a,
    output logic [23:0] axis_tdata_b,
    output logic        axis_tvalid,
    input  logic        axis_tready,
    output logic        axis_tlast,
    output logic        axis_video_tuser,
    output logic [2:0]  axis_tstrb,
    output logic [2:0]  axis_tkeep,
    output logic [15:0] line_count,
    output logic        err_short_line,
    output logic        err_no_sof
);

    localparam int WORDS = LINE_PIXELS / 2;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);

    packer_state_t           state_q, state_d;
    logic [11:0]             p0_q, p0_d;
    logic [WCW-1:0]          wcnt_q, wcnt_d;
    logic [15:0]             line_count_d;
    logic                    short_d, nosof_d;
    logic                    tuser_pend_q, tuser_pend_d;
    logic                    accept;
    logic [11:0]             sample;
    logic                    unused_pix_lsb;
    logic                    fifo_push;
    logic [FIFO_ENTRY_W-1:0] fifo_entry;
    logic [FIFO_ENTRY_W-1:0] fifo_head;
    logic                    fifo_empty, fifo_full;

    assign sample         = pix_data[15:4];
    assign unused_pix_lsb = ^pix_data[3:0];
    assign pix_ready      = !fifo_full && !read_frame_reset;
    assign accept         = pix_valid && pix_ready;

    always_ff @(posedge dphy_clk_200M or negedge rst_n_200mhz) begin
        if (!rst_n_200mhz) begin
            state_q        <= S_WAIT_SOF;
            p0_q           <= '0;
            wcnt_q         <= '0;
            line_count     <= '0;
            err_short_line <= 1'b0;
            err_no_sof     <= 1'b0;
            tuser_pend_q   <= 1'b0;
        end else if (read_frame_reset) begin
            state_q        <= S_WAIT_SOF;
            p0_q           <= '0;
            wcnt_q         <= '0;
            line_count     <= '0;
            err_short_line <= 1'b0;
            err_no_sof     <= 1'b0;
            tuser_pend_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            p0_q           <= p0_d;
            wcnt_q         <= wcnt_d;
            line_count     <= line_count_d;
            err_short_line <= short_d;
            err_no_sof     <= nosof_d;
            tuser_pend_q   <= tuser_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        p0_d         = p0_q;
        wcnt_d       = wcnt_q;
        line_count_d = line_count;
        short_d      = err_short_line;
        nosof_d      = err_no_sof;
        tuser_pend_d = tuser_pend_q;
        fifo_push    = 1'b0;
        fifo_entry   = {(wcnt_q == LAST_WORD), tuser_pend_q, pack_raw12_pair(p0_q, sample)};

        if (accept) begin
            if (pix_sof) begin
                // A new frame always restarts the line; a partial line in progress is an error.
                if (state_q == S_PIX1 || (state_q == S_PIX0 && wcnt_q != '0)) short_d = 1'b1;
                p0_d         = sample;
                wcnt_d       = '0;
                line_count_d = '0;
                tuser_pend_d = 1'b1;
                state_d      = S_PIX1;
            end else begin
                case (state_q)
                    S_WAIT_SOF: nosof_d = 1'b1;
                    S_PIX0: begin
                        p0_d    = sample;
                        state_d = S_PIX1;
                    end
                    S_PIX1: begin
                        fifo_push    = 1'b1;
                        tuser_pend_d = 1'b0;
                        state_d      = S_PIX0;
                        if (wcnt_q == LAST_WORD) begin
                            wcnt_d = '0;
                            if (line_count != 16'hFFFF) line_count_d = line_count + 16'd1;
                        end else begin
                            wcnt_d = wcnt_q + WCW'(1);
                        end
                    end
                    default: state_d = S_WAIT_SOF;
                endcase
            end
        end
    end

    mipi_pix_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (dphy_clk_200M),
        .rst_n      (rst_n_200mhz),
        .clr        (read_frame_reset),
        .push       (fifo_push),
        .push_entry (fifo_entry),
        .pop        (axis_tvalid && axis_tready),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign axis_tvalid      = !fifo_empty;
    assign axis_tdata_a     = fifo_head[23:0];
    assign axis_tdata_b     = 24'h0;
    assign axis_video_tuser = axis_tvalid && fifo_head[24];
    assign axis_tlast       = axis_tvalid && fifo_head[25];
    assign axis_tstrb       = 3'b111;
    assign axis_tkeep       = 3'b111;

endmodule

// File: tb/tb_mipi_raw12_line_packer.sv
// Directed bench: instance A packs 4-pixel lines, instance B packs 8-pixel lines; both share stimulus.
module tb_mipi_raw12_line_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rfr = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        tready = 1'b0;

    logic        ready_a, tvalid_a, tlast_a, tuser_a, short_a, nosof_a;
    logic [23:0] tdata_a, tdatab_a;
    logic [2:0]  tstrb_a, tkeep_a;
    logic [15:0] lcnt_a;

    logic        unused_ready_b, tvalid_b, tlast_b, tuser_b, short_b, unused_nosof_b;
    logic [23:0] tdata_b, unused_tdatab_b;
    logic [2:0]  unused_tstrb_b, unused_tkeep_b;
    logic [15:0] lcnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mipi_raw12_line_packer #(.LINE_PIXELS(4), .FIFO_DEPTH(16)) dut_a (
        .dphy_clk_200M(clk), .rst_n_200mhz(rst_n), .read_frame_reset(rfr),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_ready(ready_a),
        .axis_tdata_a(tdata_a), .axis_tdata_b(tdatab_a), .axis_tvalid(tvalid_a), .axis_tready(tready),
        .axis_tlast(tlast_a), .axis_video_tuser(tuser_a), .axis_tstrb(tstrb_a), .axis_tkeep(tkeep_a),
        .line_count(lcnt_a), .err_short_line(short_a), .err_no_sof(nosof_a)
    );

    mipi_raw12_line_packer #(.LINE_PIXELS(8), .FIFO_DEPTH(16)) dut_b (
        .dphy_clk_200M(clk), .rst_n_200mhz(rst_n), .read_frame_reset(rfr),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_ready(unused_ready_b),
        .axis_tdata_a(tdata_b), .axis_tdata_b(unused_tdatab_b), .axis_tvalid(tvalid_b), .axis_tready(tready),
        .axis_tlast(tlast_b), .axis_video_tuser(tuser_b), .axis_tstrb(unused_tstrb_b), .axis_tkeep(unused_tkeep_b),
        .line_count(lcnt_b), .err_short_line(short_b), .err_no_sof(unused_nosof_b)
    );

    function automatic logic [11:0] pv(input int i);
        return 12'((i * 179 + 165) & 32'hFFF);
    endfunction

    function automatic logic [23:0] exp_word(input logic [11:0] p0, input logic [11:0] p1);
        return {p1[3:0], p0[3:0], p1[11:4], p0[11:4]};
    endfunction

    // Presents one pixel from a falling edge and holds it until the rising edge that accepts it.
    task automatic push_pix(input logic [15:0] d, input logic sof);
        int  waited = 0;
        bit  done = 0;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        while (!done) begin
            if (ready_a) done = 1;
            @(posedge clk);
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL push_timeout: pixel %h not accepted within 50 cycles", d);
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic frame_reset();
        @(negedge clk);
        rfr = 1'b1;
        @(negedge clk);
        rfr = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tvalid_a, tlast_a, tuser_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got tvalid/tlast/tuser=%b required 000", {tvalid_a, tlast_a, tuser_a});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", ready_a);
        end
        n_tests++;
        if (tvalid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tvalid: got %b required 0", tvalid_a);
        end
        n_tests++;
        if ({lcnt_a, short_a, nosof_a} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got line_count=%h short=%b nosof=%b required 0", lcnt_a, short_a, nosof_a);
        end
    endtask

    task automatic test_packing();
        tready = 1'b0;
        push_pix(16'hABC0, 1'b1);
        push_pix(16'h1230, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({tvalid_a, tdata_a, tuser_a, tlast_a} !== {1'b1, 24'h3C12AB, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pack_first: got v=%b d=%h u=%b l=%b required v=1 d=3c12ab u=1 l=0",
                     tvalid_a, tdata_a, tuser_a, tlast_a);
        end
        n_tests++;
        if ({tdatab_a, tstrb_a, tkeep_a} !== {24'h0, 3'b111, 3'b111}) begin
            n_fail++;
            $display("FAIL pack_consts: got tdata_b=%h strb=%b keep=%b", tdatab_a, tstrb_a, tkeep_a);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tvalid_a, tdata_a} !== {1'b1, 24'h3C12AB}) begin
            n_fail++;
            $display("FAIL pack_hold: got v=%b d=%h required v=1 d=3c12ab", tvalid_a, tdata_a);
        end
        pop_one();
        n_tests++;
        if (tvalid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_pop: got tvalid=%b required 0", tvalid_a);
        end
        push_pix(16'h4560, 1'b0);
        push_pix(16'h7890, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({tdata_a, tuser_a, tlast_a} !== {24'h967845, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL pack_second: got d=%h u=%b l=%b required d=967845 u=0 l=1", tdata_a, tuser_a, tlast_a);
        end
        n_tests++;
        if (lcnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL pack_line_count: got %0d required 1", lcnt_a);
        end
        pop_one();
    endtask

    task automatic test_backpressure();
        frame_reset();
        tready = 1'b0;
        for (int i = 0; i < 32; i++) push_pix({pv(i), 4'h0}, i == 0);
        @(negedge clk);
        n_tests++;
        if ({ready_a, tvalid_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_full: got ready=%b tvalid=%b required ready=0 tvalid=1", ready_a, tvalid_a);
        end
        pix_valid = 1'b1;
        pix_data  = {pv(32), 4'h0};
        repeat (4) @(negedge clk);
        n_tests++;
        if (ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got ready=%b required 0", ready_a);
        end
        pix_valid = 1'b0;
        tready = 1'b1;
        for (int w = 0; w < 16; w++) begin
            n_tests++;
            if ({tvalid_a, tlast_a, tuser_a, tdata_a} !==
                {1'b1, (w % 2) == 1, w == 0, exp_word(pv(2 * w), pv(2 * w + 1))}) begin
                n_fail++;
                $display("FAIL bp_drain word %0d: got v=%b l=%b u=%b d=%h required d=%h",
                         w, tvalid_a, tlast_a, tuser_a, tdata_a, exp_word(pv(2 * w), pv(2 * w + 1)));
            end
            @(negedge clk);
        end
        n_tests++;
        if (tvalid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got tvalid=%b after 16 pops required 0", tvalid_a);
        end
        tready = 1'b0;
        push_pix({pv(32), 4'h0}, 1'b0);
        push_pix({pv(33), 4'h0}, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({tvalid_a, tlast_a, tuser_a, tdata_a} !== {3'b100, exp_word(pv(32), pv(33))}) begin
            n_fail++;
            $display("FAIL bp_resume: got v=%b l=%b u=%b d=%h required d=%h",
                     tvalid_a, tlast_a, tuser_a, tdata_a, exp_word(pv(32), pv(33)));
        end
        n_tests++;
        if (lcnt_a !== 16'd8) begin
            n_fail++;
            $display("FAIL bp_line_count: got %0d required 8", lcnt_a);
        end
        pop_one();
    endtask

    task automatic test_short_line();
        logic [23:0] exp_d [3];
        logic [2:0]  exp_u;
        exp_d[0] = 24'h212211;
        exp_d[1] = 24'h434433;
        exp_d[2] = 24'h767766;
        exp_u    = 3'b101;
        frame_reset();
        tready = 1'b0;
        push_pix(16'h1110, 1'b1);
        push_pix(16'h2220, 1'b0);
        push_pix(16'h3330, 1'b0);
        push_pix(16'h4440, 1'b0);
        push_pix(16'h5550, 1'b0);
        push_pix(16'h6660, 1'b1);
        push_pix(16'h7770, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({short_b, lcnt_b} !== {1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL short_flag: got short=%b line_count=%0d required short=1 line_count=0", short_b, lcnt_b);
        end
        tready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            n_tests++;
            if ({tvalid_b, tlast_b, tuser_b, tdata_b} !== {1'b1, 1'b0, exp_u[w], exp_d[w]}) begin
                n_fail++;
                $display("FAIL short_word %0d: got v=%b l=%b u=%b d=%h required u=%b d=%h",
                         w, tvalid_b, tlast_b, tuser_b, tdata_b, exp_u[w], exp_d[w]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (tvalid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL short_drop: got tvalid=%b after 3 words required 0", tvalid_b);
        end
        tready = 1'b0;
    endtask

    task automatic test_no_sof_abort();
        frame_reset();
        tready = 1'b0;
        push_pix(16'h0100, 1'b0);
        push_pix(16'h0200, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({tvalid_a, nosof_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL nosof_drop: got tvalid=%b err_no_sof=%b required 0 1", tvalid_a, nosof_a);
        end
        push_pix(16'h0A10, 1'b1);
        for (int i = 1; i < 6; i++) push_pix({pv(i + 40), 4'h0}, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({tvalid_a, lcnt_a} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL abort_queued: got tvalid=%b line_count=%0d required 1 1", tvalid_a, lcnt_a);
        end
        rfr = 1'b1;
        #1;
        n_tests++;
        if (ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready: got pix_ready=%b during abort required 0", ready_a);
        end
        @(negedge clk);
        rfr = 1'b0;
        n_tests++;
        if ({tvalid_a, nosof_a, short_a, lcnt_a} !== 19'h0) begin
            n_fail++;
            $display("FAIL abort_clear: got tvalid=%b nosof=%b short=%b line_count=%0d required all 0",
                     tvalid_a, nosof_a, short_a, lcnt_a);
        end
        push_pix(16'h0300, 1'b0);
        push_pix(16'h0400, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({tvalid_a, nosof_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_wait_sof: got tvalid=%b err_no_sof=%b required 0 1", tvalid_a, nosof_a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_packing();
        test_backpressure();
        test_short_line();
        test_no_sof_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
